handshake_op_stage: RTL and testbench
=====================================

Name: handshake_op_stage

Overview:
- Clocked, parametrised successor to the single-entry asynchronous increment stage.
- Sits between two 4-phase req/ack neighbours in the processor datapath chain.
- Each left-side transfer carries a data word and an operation code. The block computes the result, buffers it in a DEPTH-entry FIFO, and re-issues it on the right-side handshake.
- The left and right sides run independently, so the stage decouples producer and consumer timing.

Parameters:
- WIDTH, 8: data width of input_pins/output_pins; legal range 1..64.
- DEPTH, 2: FIFO entries; legal range 1..16, need not be a power of 2.
- INC, 1: constant operand used by the ADD/SUB ops; width WIDTH, taken modulo 2^WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_l  input  1  left request, 4-phase.
- ack_l  output  1  left acknowledge.
- input_pins  input  WIDTH  left data; must be stable while req_l=1.
- op  input  2  operation code, qualified with req_l: 00 PASS, 01 ADD INC, 10 SUB INC, 11 NEG (two's complement).
- req_r  output  1  right request, 4-phase.
- ack_r  input  1  right acknowledge.
- output_pins  output  WIDTH  right data; valid and stable while req_r=1.
- ovf_r  output  1  carry/borrow flag of the presented result; valid while req_r=1.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous): ack_l=0, req_r=0, output_pins=0, ovf_r=0, count=0. FIFO is emptied, both FSMs return to IDLE, and the synchronizer flops (if present) are cleared.
- Reset mid-transfer: any in-flight transfer is discarded. req_r drops immediately without waiting for ack_r.
- "Observed" req_l/ack_r means the raw input (default build) or the synchronizer output (SYNC_EN build).
- Left FSM, states L_IDLE and L_ACK:
  - L_IDLE -> L_ACK on an edge where observed req_l=1 and count<DEPTH. At that edge the entry {result, ovf} is written and ack_l goes to 1.
  - If count==DEPTH, the FSM stays in L_IDLE with ack_l=0 and the request stalls. There is no same-edge push-when-full, even if a pop occurs on that edge.
  - L_ACK -> L_IDLE on an edge where observed req_l=0. ack_l goes to 0.
- Right FSM, states R_IDLE, R_REQ and R_WAIT:
  - R_IDLE -> R_REQ on an edge where count>0 and observed ack_r=0. At that edge output_pins/ovf_r are loaded from the FIFO head and req_r goes to 1.
  - R_REQ -> R_WAIT on observed ack_r=1. At that edge req_r goes to 0 and the head entry is popped.
  - R_WAIT -> R_IDLE on observed ack_r=0. output_pins holds its last value.
- Simultaneous push and pop on one edge: count is unchanged and both take effect. The pointers wrap modulo DEPTH.
- Arithmetic: all results are modulo 2^WIDTH. ovf per op:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (input_pins<INC).
  - NEG: 1 iff input_pins!=0.
  - PASS: 0.
- Latency, default build: req_l sampled high at edge N gives ack_l=1 after edge N. If the FIFO was empty and the right side is idle, req_r=1 after edge N+1.
- Latency, SYNC_EN build: each observed input lags its raw input by 2 cycles.
- Illegal sequencing (for example req_l dropping before ack_l) needs no recovery; the FSMs simply follow the rules above.

Optional Feature:
- Macro: HANDSHAKE_OP_SYNC_EN.
- Defined: req_l and ack_r each pass through a 2-flop synchronizer, reset to 0, before reaching the FSMs. This is for neighbours in another clock domain or fully asynchronous neighbours. Data is not synchronized, because 4-phase protocol stability guarantees it.
- Undefined: req_l and ack_r are used directly. Neighbours must be synchronous to clk.

Test Plan:
- WIDTH=8, op=01, INC=1, input 0x41, one full 4-phase cycle each side (default build) -> ack_l=1 one edge after req_l; req_r=1 one edge later; output_pins=0x42, ovf_r=0.
- Wrap: input 0xFF with op=01 -> output 0x00, ovf_r=1. Input 0x00 with op=10 -> output 0xFF, ovf_r=1. Input 0x05 with op=11 -> output 0xFB, ovf_r=1.
- DEPTH=2, ack_r held 0, right side never answering -> three left requests: first two acked, count=2; third stalls with ack_l=0 until one pop, then is acked within 1 edge.
- Back-to-back streaming with both sides handshaking immediately, 16 words 0..15 with op=00 -> outputs 0..15 in order; count never exceeds DEPTH; no loss or duplication.
- rst_n pulsed low while req_r=1 and count=2 -> req_r, ack_l and count go to 0 asynchronously. After release, new transfer 0x10 with op=01 -> 0x11.
- HANDSHAKE_OP_SYNC_EN defined, single transfer -> ack_l rises 3 edges after req_l rises; req_r rises 1 edge after the write; payload matches the default build.

Source files
------------

// File: rtl/handshake_op_stage.sv
`default_nettype none
// ============================================================================
// Module   : handshake_op_stage
// Purpose  : 4-phase req/ack datapath stage. It applies PASS/ADD/SUB/NEG to
//            each left word and queues {ovf, result} in a DEPTH-entry FIFO for
//            the right handshake. Define HANDSHAKE_OP_SYNC_EN to add 2-flop
//            synchronizers on req_l/ack_r.
// Revision : 1.0 - initial clocked release
// ============================================================================
module handshake_op_stage #(
    parameter int              WIDTH = 8,
    parameter int              DEPTH = 2,
    parameter logic [WIDTH-1:0] INC  = WIDTH'(1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_l,
    output logic                         ack_l,
    input  logic [WIDTH-1:0]             input_pins,
    input  logic [1:0]                   op,
    output logic                         req_r,
    input  logic                         ack_r,
    output logic [WIDTH-1:0]             output_pins,
    output logic                         ovf_r,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] c_LAST  = PW'(DEPTH - 1);

    localparam logic [1:0] c_OP_ADD = 2'b01;
    localparam logic [1:0] c_OP_SUB = 2'b10;
    localparam logic [1:0] c_OP_NEG = 2'b11;

    localparam logic [0:0] c_L_IDLE = 1'b0;
    localparam logic [0:0] c_L_ACK  = 1'b1;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_REQ  = 2'd1;
    localparam logic [1:0] c_R_WAIT = 2'd2;

    logic             w_req_l;
    logic             w_ack_r;
    logic [0:0]       r_lstate;
    logic [1:0]       r_rstate;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic [WIDTH:0]   w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_load;

`ifdef HANDSHAKE_OP_SYNC_EN
    logic [1:0] r_req_l_sync;
    logic [1:0] r_ack_r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_l_sync <= 2'b00;
            r_ack_r_sync <= 2'b00;
        end else begin
            r_req_l_sync <= {r_req_l_sync[0], req_l};
            r_ack_r_sync <= {r_ack_r_sync[0], ack_r};
        end
    end

    assign w_req_l = r_req_l_sync[1];
    assign w_ack_r = r_ack_r_sync[1];
`else
    assign w_req_l = req_l;
    assign w_ack_r = ack_r;
`endif

    // Extra MSB captures carry (ADD) or borrow (SUB).
    assign w_sum  = {1'b0, input_pins} + {1'b0, INC};
    assign w_diff = {1'b0, input_pins} - {1'b0, INC};

    always_comb begin
        w_result = input_pins;
        w_ovf    = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_ovf    = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_ovf    = w_diff[WIDTH];
            end
            c_OP_NEG: begin
                w_result = (~input_pins) + WIDTH'(1);
                w_ovf    = |input_pins;
            end
            default: ;
        endcase
    end

    // Fullness is judged on the pre-edge count, so a same-edge pop never frees a slot.
    assign w_push = (r_lstate == c_L_IDLE) && w_req_l && (r_count < c_DEPTH);
    assign w_load = (r_rstate == c_R_IDLE) && (r_count != '0) && !w_ack_r;
    assign w_pop  = (r_rstate == c_R_REQ) && w_ack_r;
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lstate <= c_L_IDLE;
        end else begin
            case (r_lstate)
                c_L_IDLE: if (w_push)   r_lstate <= c_L_ACK;
                c_L_ACK:  if (!w_req_l) r_lstate <= c_L_IDLE;
                default:                r_lstate <= c_L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= c_R_IDLE;
            r_out    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_load) begin
                        r_rstate <= c_R_REQ;
                        r_out    <= w_head[WIDTH-1:0];
                        r_ovf    <= w_head[WIDTH];
                    end
                end
                c_R_REQ:  if (w_ack_r)  r_rstate <= c_R_WAIT;
                c_R_WAIT: if (!w_ack_r) r_rstate <= c_R_IDLE;
                default:                r_rstate <= c_R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + PW'(1);
            if (w_pop)  r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_ovf, w_result};
    end

    assign ack_l       = (r_lstate == c_L_ACK);
    assign req_r       = (r_rstate == c_R_REQ);
    assign output_pins = r_out;
    assign ovf_r       = r_ovf;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_handshake_op_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_op_stage
// Purpose  : Scoreboard bench for handshake_op_stage (WIDTH=8, DEPTH=2, INC=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_op_stage;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
`ifdef HANDSHAKE_OP_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             req_l       = 1'b0;
    logic             ack_l;
    logic [WIDTH-1:0] input_pins  = '0;
    logic [1:0]       op          = 2'b00;
    logic             req_r;
    logic             ack_r       = 1'b0;
    logic [WIDTH-1:0] output_pins;
    logic             ovf_r;
    logic [1:0]       count;

    int         total   = 0;
    int         bad     = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;
    logic       resp_en = 1'b0;
    logic       req_r_q = 1'b0;

    handshake_op_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INC   (8'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_l       (req_l),
        .ack_l       (ack_l),
        .input_pins  (input_pins),
        .op          (op),
        .req_r       (req_r),
        .ack_r       (ack_r),
        .output_pins (output_pins),
        .ovf_r       (ovf_r),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Monitor plus right-side responder; everything sampled on the falling edge.
    always @(negedge clk) begin
        total++;
        if (int'(count) > DEPTH) begin
            bad++;
            $display("FAIL count_bound: count=%0d max=%0d", count, DEPTH);
        end
        if (req_r && !req_r_q) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got=%h with empty queue", {ovf_r, output_pins});
            end else begin
                mon_exp = sb.pop_front();
                if ({ovf_r, output_pins} !== mon_exp) begin
                    bad++;
                    $display("FAIL output_word: got=%h expected=%h", {ovf_r, output_pins}, mon_exp);
                end
            end
        end
        req_r_q = req_r;
        if (!rst_n)
            ack_r = 1'b0;
        else if (resp_en) begin
            if (req_r && !ack_r)      ack_r = 1'b1;
            else if (!req_r && ack_r) ack_r = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic lreq(input logic [7:0] d, input logic [1:0] o, input logic [8:0] e);
        @(negedge clk);
        input_pins = d;
        op         = o;
        req_l      = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ack_l !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ack_l), 32'(lvl));
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] o, input logic [8:0] e);
        lreq(d, o, e);
        wait_ack(1'b1, "ack_rise");
        req_l = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || req_r || count != 0 || ack_r) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_ack_l", 32'(ack_l), 32'd0);
        check("rst_req_r", 32'(req_r), 32'd0);
        check("rst_output", 32'(output_pins), 32'd0);
        check("rst_ovf", 32'(ovf_r), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer with latency measurement
        resp_en = 1'b1;
        lreq(8'h41, 2'b01, 9'h042);
        k = 0;
        while (!ack_l && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("ack_latency", 32'(k), 32'(ACK_LAT));
        check("req_r_not_yet", 32'(req_r), 32'd0);
        @(negedge clk);
        check("req_r_latency", 32'(req_r), 32'd1);
        req_l = 1'b0;
        wait_ack(1'b0, "ack_fall");
        drain("drain_single");

        // Arithmetic corner vectors
        send(8'hFF, 2'b01, 9'h100);
        send(8'h00, 2'b10, 9'h1FF);
        send(8'h05, 2'b11, 9'h1FB);
        send(8'h00, 2'b11, 9'h000);
        send(8'h10, 2'b10, 9'h00F);
        send(8'h7E, 2'b00, 9'h07E);
        drain("drain_wrap");

        // Full FIFO stalls the third request until a pop
        resp_en = 1'b0;
        send(8'hA0, 2'b00, 9'h0A0);
        send(8'hA1, 2'b01, 9'h0A2);
        check("full_count", 32'(count), 32'd2);
        check("full_req_r", 32'(req_r), 32'd1);
        lreq(8'hA2, 2'b10, 9'h0A1);
        repeat (6) @(negedge clk);
        check("stall_ack_low", 32'(ack_l), 32'd0);
        check("stall_count", 32'(count), 32'd2);
        resp_en = 1'b1;
        wait_ack(1'b1, "stall_release");
        req_l = 1'b0;
        wait_ack(1'b0, "ack_fall");
        drain("drain_stall");

        // Streaming 0..15
        for (int i = 0; i < 16; i++)
            send(8'(i), 2'b00, {1'b0, 8'(i)});
        drain("drain_stream");

        // Asynchronous reset while the FIFO is full and req_r is high
        resp_en = 1'b0;
        send(8'h30, 2'b01, 9'h031);
        send(8'h31, 2'b01, 9'h032);
        check("pre_rst_count", 32'(count), 32'd2);
        check("pre_rst_req_r", 32'(req_r), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_r", 32'(req_r), 32'd0);
        check("async_rst_ack_l", 32'(ack_l), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_output", 32'(output_pins), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        send(8'h10, 2'b01, 9'h011);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
